// File: rtl/mem_pkg.sv
// Shared encodings for the CPU-side memory access controller: access sizes,
// controller FSM states and RAM RW polarity.
package mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE    = 2'b00,
    SZ_HALF    = 2'b01,
    SZ_WORD    = 2'b10,
    SZ_ILLEGAL = 2'b11
  } size_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_SETUP,
    ST_ASSERT,
    ST_RELEASE,
    ST_DONE
  } state_e;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  function automatic logic [2:0] beats_for(input size_e sz);
    case (sz)
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd1;
    endcase
  endfunction

  function automatic logic bad_access(input size_e sz, input logic [1:0] a_lo);
    case (sz)
      SZ_BYTE: return 1'b0;
      SZ_HALF: return a_lo[0];
      SZ_WORD: return a_lo != 2'b00;
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_if.sv
// Request/response bus of the memory access controller plus the byte-wide
// RAM handshake (Enable/MOV/RW/MOC). slave = controller, master = environment.
interface mem_access_ctrl_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              req;
  logic              we;
  logic [1:0]        size;
  logic              sign_ext;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic              busy;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_enable;
  logic              mem_mov;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_moc;

  modport slave (
    input  req, we, size, sign_ext, addr, wdata, mem_rdata, mem_moc,
    output busy, done, err, rdata, mem_enable, mem_mov, mem_rw, mem_addr, mem_wdata
  );

  modport master (
    output req, we, size, sign_ext, addr, wdata, mem_rdata, mem_moc,
    input  busy, done, err, rdata, mem_enable, mem_mov, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/load_align.sv
// Turns the big-endian byte capture register into the 32-bit load result,
// sign- or zero-extending byte and halfword loads.
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] cap_i,
  input  size_e       size_i,
  input  logic        sign_ext_i,
  output logic [31:0] rdata_o
);

  always_comb begin
    rdata_o = cap_i;
    case (size_i)
      SZ_BYTE: rdata_o = {{24{sign_ext_i & cap_i[7]}}, cap_i[7:0]};
      SZ_HALF: rdata_o = {{16{sign_ext_i & cap_i[15]}}, cap_i[15:0]};
      default: rdata_o = cap_i;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Splits byte/half/word load-store requests into byte-wide four-phase RAM
// beats, assembles big-endian load data and reports done/err.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned TIMEOUT = 16
) (
  input logic               clk,
  input logic               reset,
  mem_access_ctrl_if.slave  bus
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic              we_q, we_d;
  size_e             size_q, size_d;
  logic              sext_q, sext_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       cap_q, cap_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        idx_q, idx_d;
  logic              err_q, err_d;
  logic [TW-1:0]     tmo_q, tmo_d;

  logic [2:0]  nbeat;
  logic [1:0]  lane;
  logic        last_beat;
  logic        tmo_hit;
  logic        in_beat;
  logic [31:0] aligned;
  logic        unused_rdata_hi;

  assign nbeat     = beats_for(size_q);
  assign lane      = 2'(nbeat - 3'd1 - {1'b0, idx_q});
  assign last_beat = ({1'b0, idx_q} == (nbeat - 3'd1));
  assign tmo_hit   = (tmo_q == TW'(TIMEOUT - 1));
  assign unused_rdata_hi = ^bus.mem_rdata[31:8];

  load_align u_load_align (
    .cap_i      (cap_q),
    .size_i     (size_q),
    .sign_ext_i (sext_q),
    .rdata_o    (aligned)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      sext_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cap_q   <= '0;
      rdata_q <= '0;
      idx_q   <= '0;
      err_q   <= 1'b0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      size_q  <= size_d;
      sext_q  <= sext_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cap_q   <= cap_d;
      rdata_q <= rdata_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
      tmo_q   <= tmo_d;
    end
  end

  // SETUP also waits for MOC low so MOV can never rise over a stale MOC.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    size_d  = size_q;
    sext_d  = sext_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    idx_d   = idx_q;
    err_d   = err_q;
    tmo_d   = tmo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          size_d  = size_e'(bus.size);
          sext_d  = bus.sign_ext;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          err_d   = 1'b0;
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (bad_access(size_q, addr_q[1:0])) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          idx_d   = '0;
          tmo_d   = '0;
          state_d = ST_SETUP;
        end
      end
      ST_SETUP: begin
        if (!bus.mem_moc) begin
          tmo_d   = '0;
          state_d = ST_ASSERT;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_ASSERT: begin
        if (bus.mem_moc) begin
          if (!we_q) cap_d[{lane, 3'b000} +: 8] = bus.mem_rdata[7:0];
          tmo_d   = '0;
          state_d = ST_RELEASE;
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_RELEASE: begin
        if (!bus.mem_moc) begin
          tmo_d = '0;
          if (last_beat) begin
            if (!we_q) rdata_d = aligned;
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 2'd1;
            state_d = ST_SETUP;
          end
        end else if (tmo_hit) begin
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_beat        = (state_q == ST_SETUP) || (state_q == ST_ASSERT) || (state_q == ST_RELEASE);
    bus.busy       = (state_q != ST_IDLE);
    bus.done       = (state_q == ST_DONE);
    bus.err        = (state_q == ST_DONE) && err_q;
    bus.rdata      = rdata_q;
    bus.mem_enable = in_beat;
    bus.mem_mov    = (state_q == ST_ASSERT);
    bus.mem_rw     = (in_beat && !we_q) ? RW_READ : RW_WRITE;
    bus.mem_addr   = in_beat ? addr_q + ADDR_W'(idx_q) : '0;
    bus.mem_wdata  = in_beat ? {24'h000000, wdata_q[{lane, 3'b000} +: 8]} : '0;
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: directed vector table, handshake corner cases and
// randomized traffic against a byte-array reference model with a RAM responder.
module tb_mem_access_ctrl;

  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned TIMEOUT = 16;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_access_ctrl_if #(.ADDR_W(ADDR_W)) bus ();

  mem_access_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int checks   = 0;
  int failures = 0;

  // RAM responder: raises MOC ram_delay edges after MOV, drops it when MOV drops.
  logic [7:0]  ram   [256] = '{default: 8'h00};
  logic [7:0]  model [256] = '{default: 8'h00};
  int unsigned ram_delay = 0;
  int unsigned dly_cnt   = 0;
  logic        ram_stuck = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      bus.mem_moc   <= 1'b0;
      bus.mem_rdata <= 32'h0;
      dly_cnt       <= 0;
    end else if (!bus.mem_mov) begin
      bus.mem_moc <= 1'b0;
      dly_cnt     <= 0;
    end else if (!bus.mem_moc && !ram_stuck) begin
      if (dly_cnt < ram_delay) dly_cnt <= dly_cnt + 1;
      else begin
        bus.mem_moc <= 1'b1;
        dly_cnt     <= 0;
        if (bus.mem_rw == 1'b0) ram[bus.mem_addr] <= bus.mem_wdata[7:0];
        else bus.mem_rdata <= {24'hA5C35A, ram[bus.mem_addr]};
      end
    end
  end

  // Handshake monitor: counts beats/done pulses, flags protocol violations.
  logic        prev_mov = 1'b0;
  logic [40:0] prev_beat = '0;
  int          beat_total = 0;
  int          done_total = 0;
  int          viol = 0;

  always @(posedge clk) begin
    prev_mov  <= bus.mem_mov;
    prev_beat <= {bus.mem_addr, bus.mem_wdata, bus.mem_rw};
    if (bus.mem_mov && !prev_mov) beat_total <= beat_total + 1;
    if (bus.mem_mov && !prev_mov && bus.mem_moc) viol <= viol + 1;
    if (bus.mem_mov && prev_mov && ({bus.mem_addr, bus.mem_wdata, bus.mem_rw} != prev_beat))
      viol <= viol + 1;
    if (bus.done) done_total <= done_total + 1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Issues one request and waits (bounded) for done; checks single done pulse.
  task automatic do_txn(input logic we, input logic [1:0] sz, input logic sx,
                        input logic [7:0] a, input logic [31:0] wd, input int intrude_at,
                        output logic got_err, output logic [31:0] got_rd,
                        output int lat, output int movc, output int beats,
                        output logic mov_at_done);
    int bstart;
    int dstart;
    bstart       = beat_total;
    dstart       = done_total;
    bus.req      = 1'b1;
    bus.we       = we;
    bus.size     = sz;
    bus.sign_ext = sx;
    bus.addr     = a;
    bus.wdata    = wd;
    @(negedge clk);
    bus.req = 1'b0;
    lat     = 1;
    movc    = 0;
    while (!bus.done && lat < 400) begin
      if (bus.mem_mov) movc++;
      if (lat == intrude_at) begin
        bus.req   = 1'b1;
        bus.we    = 1'b1;
        bus.size  = 2'b00;
        bus.addr  = 8'h70;
        bus.wdata = 32'h000000AA;
      end else bus.req = 1'b0;
      @(negedge clk);
      lat++;
    end
    bus.req = 1'b0;
    chk("done_within_budget", 32'(bus.done), 32'd1);
    got_err     = bus.err;
    got_rd      = bus.rdata;
    mov_at_done = bus.mem_mov;
    @(negedge clk);
    beats = beat_total - bstart;
    chk("done_single_pulse", 32'(done_total - dstart), 32'd1);
    chk("busy_after_done", {31'b0, bus.busy}, 32'd0);
  endtask

  logic [31:0] hold = 32'h0;

  function automatic void model_txn(input logic we, input logic [1:0] sz, input logic sx,
                                    input logic [7:0] a, input logic [31:0] wd,
                                    output logic e, output logic [31:0] rd, output int n);
    logic [31:0] v;
    n  = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    e  = (sz == 2'd3) || ((int'(a) % n) != 0);
    rd = hold;
    if (e) n = 0;
    else if (we) begin
      for (int k = 0; k < n; k++) model[8'(int'(a) + k)] = 8'(wd >> (8 * (n - 1 - k)));
    end else begin
      v = 32'h0;
      for (int k = 0; k < n; k++) v = (v << 8) | {24'h0, model[8'(int'(a) + k)]};
      if (n < 4 && sx && v[8*n-1]) v = v | ~((32'h1 << (8 * n)) - 32'h1);
      rd   = v;
      hold = v;
    end
  endfunction

  typedef struct {
    logic        we;
    logic [1:0]  sz;
    logic        sx;
    logic [7:0]  a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
    int          lat;
    int          beats;
  } vec_t;

  vec_t vt [12];

  initial begin
    logic        e, md, exp_e;
    logic [31:0] rd, exp_rd;
    int          lat, movc, beats, exp_n;
    logic [1:0]  sz;
    logic [7:0]  a;

    vt[0]  = '{1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 1'b0, 32'h00000000, 22, 4};
    vt[1]  = '{1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        1'b0, 32'hDEADBEEF, 22, 4};
    vt[2]  = '{1'b0, 2'd0, 1'b1, 8'h12, 32'h0,        1'b0, 32'hFFFFFFBE,  7, 1};
    vt[3]  = '{1'b0, 2'd0, 1'b0, 8'h12, 32'h0,        1'b0, 32'h000000BE,  7, 1};
    vt[4]  = '{1'b1, 2'd1, 1'b0, 8'h20, 32'h00008001, 1'b0, 32'h000000BE, 12, 2};
    vt[5]  = '{1'b0, 2'd1, 1'b1, 8'h20, 32'h0,        1'b0, 32'hFFFF8001, 12, 2};
    vt[6]  = '{1'b0, 2'd2, 1'b0, 8'h21, 32'h0,        1'b1, 32'hFFFF8001,  2, 0};
    vt[7]  = '{1'b0, 2'd1, 1'b1, 8'h23, 32'h0,        1'b1, 32'hFFFF8001,  2, 0};
    vt[8]  = '{1'b1, 2'd3, 1'b0, 8'h30, 32'h12345678, 1'b1, 32'hFFFF8001,  2, 0};
    vt[9]  = '{1'b0, 2'd1, 1'b0, 8'h20, 32'h0,        1'b0, 32'h00008001, 12, 2};
    vt[10] = '{1'b1, 2'd0, 1'b0, 8'h25, 32'h1234565A, 1'b0, 32'h00008001,  7, 1};
    vt[11] = '{1'b0, 2'd0, 1'b1, 8'h25, 32'h0,        1'b0, 32'h0000005A,  7, 1};

    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.we       = 1'b0;
    bus.size     = 2'b00;
    bus.sign_ext = 1'b0;
    bus.addr     = '0;
    bus.wdata    = '0;
    repeat (3) @(negedge clk);
    chk("reset_ctrl_outputs", {29'b0, bus.busy, bus.done, bus.err}, 32'd0);
    chk("reset_rdata", bus.rdata, 32'd0);
    chk("reset_mem_outputs", {bus.mem_enable, bus.mem_mov, bus.mem_rw, bus.mem_addr, bus.mem_wdata[20:0]}, 32'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      do_txn(vt[i].we, vt[i].sz, vt[i].sx, vt[i].a, vt[i].wd, 0, e, rd, lat, movc, beats, md);
      chk($sformatf("vec%0d_err", i), {31'b0, e}, {31'b0, vt[i].err});
      chk($sformatf("vec%0d_rdata", i), rd, vt[i].rd);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
      chk($sformatf("vec%0d_beats", i), 32'(beats), 32'(vt[i].beats));
    end
    chk("ram_word_store", {ram[8'h10], ram[8'h11], ram[8'h12], ram[8'h13]}, 32'hDEADBEEF);
    chk("ram_half_store", {16'h0, ram[8'h20], ram[8'h21]}, 32'h00008001);
    chk("ram_illegal_untouched", {24'h0, ram[8'h30]}, 32'h0);

    // RAM never answers: abort after TIMEOUT cycles of MOV.
    ram_stuck = 1'b1;
    do_txn(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 0, e, rd, lat, movc, beats, md);
    chk("timeout_err", {31'b0, e}, 32'd1);
    chk("timeout_rdata_kept", rd, 32'h0000005A);
    chk("timeout_mov_cycles", 32'(movc), 32'(TIMEOUT));
    chk("timeout_mov_low_at_done", {31'b0, md}, 32'd0);
    ram_stuck = 1'b0;
    @(negedge clk);

    // Reset while beat 2 of a word store is in its MOV phase.
    begin
      int dstart;
      int w;
      dstart       = done_total;
      bus.req      = 1'b1;
      bus.we       = 1'b1;
      bus.size     = 2'd2;
      bus.addr     = 8'h60;
      bus.wdata    = 32'hCAFEF00D;
      @(negedge clk);
      bus.req = 1'b0;
      w = 0;
      while (!(bus.mem_mov && bus.mem_addr == 8'h62) && w < 100) begin
        @(negedge clk);
        w++;
      end
      chk("reach_beat2_assert", 32'(bus.mem_mov && bus.mem_addr == 8'h62), 32'd1);
      reset = 1'b1;
      @(negedge clk);
      chk("midreset_ctrl_outputs", {29'b0, bus.busy, bus.done, bus.err}, 32'd0);
      chk("midreset_rdata", bus.rdata, 32'd0);
      chk("midreset_mem_outputs", {bus.mem_enable, bus.mem_mov, bus.mem_rw, bus.mem_addr, bus.mem_wdata[20:0]}, 32'd0);
      reset = 1'b0;
      @(negedge clk);
      chk("midreset_no_done", 32'(done_total - dstart), 32'd0);
    end

    // Normal request after reset, with an ignored request pulsed while busy.
    begin
      int dstart;
      do_txn(1'b0, 2'd2, 1'b0, 8'h10, 32'h0, 3, e, rd, lat, movc, beats, md);
      dstart = done_total;
      chk("post_reset_load", rd, 32'hDEADBEEF);
      chk("post_reset_err", {31'b0, e}, 32'd0);
      repeat (6) @(negedge clk);
      chk("busy_req_not_queued", {31'b0, bus.busy}, 32'd0);
      chk("busy_req_no_done", 32'(done_total - dstart), 32'd0);
      chk("busy_req_no_write", {24'h0, ram[8'h70]}, 32'd0);
      hold = 32'hDEADBEEF;
    end

    // Randomized traffic in the upper half of RAM with variable RAM latency.
    for (int i = 0; i < 60; i++) begin
      logic        we_r, sx_r;
      logic [31:0] wd_r;
      we_r = 1'($urandom_range(0, 1));
      sx_r = 1'($urandom_range(0, 1));
      wd_r = $urandom;
      sz   = 2'($urandom_range(0, 3));
      a    = 8'(8'h80 + $urandom_range(0, 127));
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        else if (sz == 2'd2) a[1:0] = 2'b00;
      end
      ram_delay = $urandom_range(0, 2);
      model_txn(we_r, sz, sx_r, a, wd_r, exp_e, exp_rd, exp_n);
      do_txn(we_r, sz, sx_r, a, wd_r, 0, e, rd, lat, movc, beats, md);
      chk($sformatf("rand%0d_err", i), {31'b0, e}, {31'b0, exp_e});
      chk($sformatf("rand%0d_rdata", i), rd, exp_rd);
      chk($sformatf("rand%0d_beats", i), 32'(beats), 32'(exp_n));
    end

    chk("handshake_violations", 32'(viol), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
